// File: rtl/line_ram_sequencer.sv
// line_ram_sequencer: arbitrates GCN line reads/writes onto a single
// valid/ready RAM port, splitting each 128-bit line into four 32-bit beats
// and reassembling read beats into a line. One line in flight at a time.
module line_ram_sequencer #(
  parameter int unsigned ADDR_BITS  = 32,
  parameter int unsigned DATA_BITS  = 32,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned WORD_BITS  = 16,
  parameter int unsigned LADDR_BITS = 28
) (
  input  logic                            clock,
  input  logic                            reset,
  // line read port
  input  logic [LADDR_BITS-1:0]           rd_addr,
  input  logic                            rd_req,
  output logic                            rd_gnt,
  output logic                            rd_valid,
  output logic [LINE_WORDS*WORD_BITS-1:0] rd_data,
  // line write port
  input  logic [LADDR_BITS-1:0]           wr_addr,
  input  logic                            wr_req,
  output logic                            wr_gnt,
  input  logic [LINE_WORDS*WORD_BITS-1:0] wr_data,
  // RAM address channel
  output logic                            cntl2ram_a_valid,
  input  logic                            cntl2ram_a_ready,
  output logic                            cntl2ram_a_write,
  output logic [ADDR_BITS-1:0]            cntl2ram_a_addr,
  // RAM write data channel
  output logic                            cntl2ram_w_valid,
  input  logic                            cntl2ram_w_ready,
  output logic [DATA_BITS-1:0]            cntl2ram_w_data,
  // RAM read data channel
  input  logic                            ram2cntl_r_valid,
  output logic                            ram2cntl_r_ready,
  input  logic [DATA_BITS-1:0]            ram2cntl_r_data
);

  localparam int unsigned LINE_BITS = LINE_WORDS * WORD_BITS;
  localparam int unsigned BEATS     = LINE_BITS / DATA_BITS;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_R,
    RD_DONE,
    WR_A,
    WR_W
  } state_e;

  state_e                              state_q, state_d;
  logic [1:0]                          beat_q, beat_d;
  logic                                last_wr_q, last_wr_d;
  logic [LADDR_BITS-1:0]               addr_q, addr_d;
  logic [BEATS-1:0][DATA_BITS-1:0]     wbuf_q, wbuf_d;
  logic [BEATS-1:0][DATA_BITS-1:0]     rbuf_q, rbuf_d;
  logic [LINE_BITS-1:0]                rdata_q, rdata_d;

  // Beat address and write data come straight from the held registers, so
  // they stay stable for as long as the beat is stalled.
  assign cntl2ram_a_addr = {addr_q, beat_q, 2'b00};
  assign cntl2ram_w_data = wbuf_q[beat_q];
  assign rd_data         = rdata_q;

  // State and datapath registers; reset abandons any line in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      last_wr_q <= 1'b1;
      addr_q    <= '0;
      wbuf_q    <= '0;
      rbuf_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      last_wr_q <= last_wr_d;
      addr_q    <= addr_d;
      wbuf_q    <= wbuf_d;
      rbuf_q    <= rbuf_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    last_wr_d        = last_wr_q;
    addr_d           = addr_q;
    wbuf_d           = wbuf_q;
    rbuf_d           = rbuf_q;
    rdata_d          = rdata_q;
    rd_gnt           = 1'b0;
    wr_gnt           = 1'b0;
    rd_valid         = 1'b0;
    cntl2ram_a_valid = 1'b0;
    cntl2ram_a_write = 1'b0;
    cntl2ram_w_valid = 1'b0;
    ram2cntl_r_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Read wins when it is alone or when the write was served last.
        if (rd_req && (!wr_req || last_wr_q)) begin
          rd_gnt    = 1'b1;
          addr_d    = rd_addr;
          beat_d    = '0;
          last_wr_d = 1'b0;
          state_d   = RD_A;
        end else if (wr_req) begin
          wr_gnt    = 1'b1;
          addr_d    = wr_addr;
          wbuf_d    = wr_data;
          beat_d    = '0;
          last_wr_d = 1'b1;
          state_d   = WR_A;
        end
      end

      RD_A: begin
        cntl2ram_a_valid = 1'b1;
        if (cntl2ram_a_ready) begin
          state_d = RD_R;
        end
      end

      RD_R: begin
        ram2cntl_r_ready = 1'b1;
        if (ram2cntl_r_valid) begin
          rbuf_d[beat_q] = ram2cntl_r_data;
          if (beat_q == 2'd3) begin
            // Publish the whole line, last beat included, in one step.
            rdata_d = rbuf_d;
            state_d = RD_DONE;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = RD_A;
          end
        end
      end

      RD_DONE: begin
        rd_valid = 1'b1;
        state_d  = IDLE;
      end

      WR_A: begin
        cntl2ram_a_valid = 1'b1;
        cntl2ram_a_write = 1'b1;
        if (cntl2ram_a_ready) begin
          state_d = WR_W;
        end
      end

      WR_W: begin
        cntl2ram_w_valid = 1'b1;
        if (cntl2ram_w_ready) begin
          if (beat_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = WR_A;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_line_ram_sequencer.sv
// Bench for line_ram_sequencer: a RAM model with optional stalls, a
// scoreboard of expected beats/lines, a vector table and corner sequences.
module tb_line_ram_sequencer;

  logic         clock = 1'b0;
  logic         reset;
  logic [27:0]  rd_addr, wr_addr;
  logic         rd_req, wr_req, rd_gnt, wr_gnt, rd_valid;
  logic [127:0] rd_data, wr_data;
  logic         a_valid, a_ready, a_write;
  logic [31:0]  a_addr;
  logic         w_valid, w_ready;
  logic [31:0]  w_data;
  logic         r_valid, r_ready;
  logic [31:0]  r_data;

  always #5 clock = ~clock;

  line_ram_sequencer #(
    .ADDR_BITS (32),
    .DATA_BITS (32),
    .LINE_WORDS(8),
    .WORD_BITS (16),
    .LADDR_BITS(28)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .rd_addr         (rd_addr),
    .rd_req          (rd_req),
    .rd_gnt          (rd_gnt),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .wr_addr         (wr_addr),
    .wr_req          (wr_req),
    .wr_gnt          (wr_gnt),
    .wr_data         (wr_data),
    .cntl2ram_a_valid(a_valid),
    .cntl2ram_a_ready(a_ready),
    .cntl2ram_a_write(a_write),
    .cntl2ram_a_addr (a_addr),
    .cntl2ram_w_valid(w_valid),
    .cntl2ram_w_ready(w_ready),
    .cntl2ram_w_data (w_data),
    .ram2cntl_r_valid(r_valid),
    .ram2cntl_r_ready(r_ready),
    .ram2cntl_r_data (r_data)
  );

  typedef struct {
    logic        w;
    logic [31:0] addr;
  } abeat_t;

  typedef struct {
    logic [31:0] addr;
    int          dly;
  } rpend_t;

  typedef struct {
    bit           wr;
    logic [27:0]  line;
    logic [31:0]  addr0;
    logic [127:0] data;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  abeat_t       exp_a[$];
  logic [31:0]  exp_w[$];
  logic [127:0] exp_rd[$];
  rpend_t       rpend[$];
  logic [31:0]  wpend[$];
  logic [31:0]  mem[logic [31:0]];

  bit  stall = 0;
  bit  lat_en = 1;
  int  rdly_min = 0;
  int  rdly_max = 0;
  bit  busy = 0;
  int  gcyc = 0;
  int  wcnt = 0;
  int  rd_a_hs = 0;
  bit  prev_a_stall = 0, prev_w_stall = 0;
  logic        prev_a_write;
  logic [31:0] prev_a_addr, prev_w_data;
  abeat_t      e;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [159:0] act,
                                input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name, input logic [159:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h want nothing", name, act);
  endfunction

  // RAM model and scoreboard: drive the RAM side just after the falling
  // edge, then judge the handshakes that the next rising edge will take.
  always @(negedge clock) begin
    if (reset) begin
      a_ready = 1'b0;
      w_ready = 1'b0;
      r_valid = 1'b0;
      r_data  = '0;
      exp_a.delete();
      exp_w.delete();
      exp_rd.delete();
      rpend.delete();
      wpend.delete();
      busy = 0;
      prev_a_stall = 0;
      prev_w_stall = 0;
    end else begin
      if (rpend.size() > 0 && rpend[0].dly == 0) begin
        r_valid = 1'b1;
        r_data  = mem.exists(rpend[0].addr) ? mem[rpend[0].addr] : 32'h0;
      end else begin
        r_valid = 1'b0;
        r_data  = '0;
        if (rpend.size() > 0) rpend[0].dly = rpend[0].dly - 1;
      end
      a_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      w_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (prev_a_stall)
        check("a_hold", {a_valid, a_write, a_addr}, {1'b1, prev_a_write, prev_a_addr});
      if (prev_w_stall)
        check("w_hold", {w_valid, w_data}, {1'b1, prev_w_data});

      if (a_valid && a_ready) begin
        if (exp_a.size() == 0) unexpected("a_beat", {a_write, a_addr});
        else begin
          e = exp_a.pop_front();
          check("a_beat", {a_write, a_addr}, {e.w, e.addr});
        end
        if (a_write) wpend.push_back(a_addr);
        else begin
          rpend.push_back('{a_addr, int'($urandom_range(rdly_max, rdly_min))});
          rd_a_hs++;
        end
      end
      prev_a_stall = a_valid && !a_ready;
      prev_a_addr  = a_addr;
      prev_a_write = a_write;

      if (w_valid && w_ready) begin
        if (exp_w.size() == 0) unexpected("w_data", w_data);
        else check("w_data", w_data, exp_w.pop_front());
        if (wpend.size() > 0) mem[wpend.pop_front()] = w_data;
        wcnt++;
        if (wcnt == 4) begin
          busy = 0;
          if (lat_en) check("wr_latency", cyc - gcyc, 8);
        end
      end
      prev_w_stall = w_valid && !w_ready;
      prev_w_data  = w_data;

      if (r_valid) begin
        check("r_ready", r_ready, 1'b1);
        if (r_ready) void'(rpend.pop_front());
      end

      if (rd_valid) begin
        if (exp_rd.size() == 0) unexpected("rd_data", rd_data);
        else check("rd_data", rd_data, exp_rd.pop_front());
        busy = 0;
        if (lat_en) check("rd_latency", cyc - gcyc, 9);
      end

      if (rd_gnt || wr_gnt) begin
        check("gnt_idle", {busy, rd_gnt & wr_gnt}, 2'b00);
        busy = 1;
        gcyc = cyc;
        wcnt = 0;
      end
    end
  end

  task automatic push_exp(input bit w, input logic [31:0] addr0, input logic [127:0] data);
    for (int b = 0; b < 4; b++) begin
      exp_a.push_back('{w, addr0 + 32'(4 * b)});
      if (w) exp_w.push_back(data[32*b +: 32]);
    end
    if (!w) exp_rd.push_back(data);
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clock); #3;
      done = !busy && exp_a.size() == 0 && exp_w.size() == 0 && exp_rd.size() == 0;
    end
    check(name, done, 1'b1);
  endtask

  task automatic wait_gnt(input bit w);
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock); #2;
      got = w ? wr_gnt : rd_gnt;
    end
    check(w ? "wr_gnt_seen" : "rd_gnt_seen", got, 1'b1);
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {rd_gnt, wr_gnt, rd_valid, a_valid, a_write, w_valid, r_ready,
                 a_addr, w_data, rd_data}, '0);
  endtask

  // One line transaction; poke raises a competing read while a write is busy.
  task automatic do_txn(input bit w, input logic [27:0] line, input logic [31:0] addr0,
                        input logic [127:0] data, input bit poke);
    int pk = 0;
    push_exp(w, addr0, data);
    @(posedge clock); #1;
    if (w) begin
      wr_addr = line;
      wr_data = data;
      wr_req  = 1'b1;
    end else begin
      rd_addr = line;
      rd_req  = 1'b1;
    end
    wait_gnt(w);
    @(posedge clock); #1;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    wr_data = ~data;
    wr_addr = ~line;
    rd_addr = ~line;
    if (poke) begin
      rd_addr = 28'h0000077;
      rd_req  = 1'b1;
      repeat (3) begin
        @(negedge clock); #2;
        pk += int'(rd_gnt);
      end
      @(posedge clock); #1;
      rd_req = 1'b0;
      check("poke_no_gnt", pk, 0);
    end
    wait_idle("txn_done");
  endtask

  localparam logic [127:0] D10A = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
  localparam logic [127:0] D11  = 128'hA7A7_A6A6_A5A5_A4A4_A3A3_A2A2_A1A1_A0A0;
  localparam logic [127:0] D10B = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
  localparam logic [127:0] DTOP = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;
  localparam logic [127:0] D20  = 128'h5A5A_A5A5_3C3C_C3C3_0FF0_F00F_1357_2468;

  vec_t vecs[9];

  initial begin : main
    int   n;
    logic [3:0] order;
    int   base;
    bit   hit;

    vecs[0] = '{1'b1, 28'h0000010, 32'h0000_0100, D10A};
    vecs[1] = '{1'b0, 28'h0000010, 32'h0000_0100, D10A};
    vecs[2] = '{1'b1, 28'h0000011, 32'h0000_0110, D11};
    vecs[3] = '{1'b0, 28'h0000011, 32'h0000_0110, D11};
    vecs[4] = '{1'b0, 28'h0000005, 32'h0000_0050, 128'h0};
    vecs[5] = '{1'b1, 28'h0000010, 32'h0000_0100, D10B};
    vecs[6] = '{1'b0, 28'h0000010, 32'h0000_0100, D10B};
    vecs[7] = '{1'b1, 28'hFFFFFFF, 32'hFFFF_FFF0, DTOP};
    vecs[8] = '{1'b0, 28'hFFFFFFF, 32'hFFFF_FFF0, DTOP};

    reset   = 1'b1;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    a_ready = 1'b0;
    w_ready = 1'b0;
    r_valid = 1'b0;
    r_data  = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock); #2;
    check_idle_outputs("reset_state");

    // Both requesters held from reset: read first, then alternate.
    push_exp(1'b0, 32'h0000_0200, 128'h0);
    push_exp(1'b1, 32'h0000_0200, D20);
    push_exp(1'b0, 32'h0000_0200, D20);
    push_exp(1'b1, 32'h0000_0200, D20);
    @(posedge clock); #1;
    rd_addr = 28'h0000020;
    wr_addr = 28'h0000020;
    wr_data = D20;
    rd_req  = 1'b1;
    wr_req  = 1'b1;
    n = 0;
    order = '0;
    for (int i = 0; i < 300 && n < 4; i++) begin
      @(negedge clock); #2;
      if (rd_gnt || wr_gnt) begin
        order[n] = wr_gnt;
        n++;
      end
    end
    @(posedge clock); #1;
    rd_req = 1'b0;
    wr_req = 1'b0;
    check("rr_grants", n, 4);
    check("rr_order", order, 4'b1010);
    wait_idle("rr_done");

    // Zero-wait RAM: exact latencies are checked by the scoreboard.
    for (int i = 0; i < 9; i++)
      do_txn(vecs[i].wr, vecs[i].line, vecs[i].addr0, vecs[i].data, 1'b0);

    // Random stalls and read delays; competing read poked during writes.
    stall    = 1;
    lat_en   = 0;
    rdly_min = 0;
    rdly_max = 5;
    for (int i = 0; i < 9; i++)
      do_txn(vecs[i].wr, vecs[i].line, vecs[i].addr0, vecs[i].data, vecs[i].wr);

    // Reset while the third read beat is outstanding.
    stall    = 0;
    rdly_min = 5;
    rdly_max = 5;
    push_exp(1'b0, 32'h0000_0100, D10B);
    base = rd_a_hs;
    @(posedge clock); #1;
    rd_addr = 28'h0000010;
    rd_req  = 1'b1;
    wait_gnt(1'b0);
    @(posedge clock); #1;
    rd_req = 1'b0;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clock); #2;
      hit = (rd_a_hs == base + 3);
    end
    check("third_rd_beat", hit, 1'b1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock); #2;
    check_idle_outputs("mid_reset_state");
    rdly_min = 0;
    rdly_max = 0;
    lat_en   = 1;
    do_txn(1'b0, 28'h0000010, 32'h0000_0100, D10B, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
